// File: rtl/rf_param_bypass.sv
// -----------------------------------------------------------------------------
// rf_param_bypass
//
// Parametrised register file for the decode stage. It has two combinational
// read ports and one synchronous write port. It also contains a sequenced
// bulk-clear engine.
//
// Optional features:
//   - same-cycle write-to-read forwarding (BYPASS)
//   - hardwired zero register 0 (ZERO_REG)
//
// The clear engine walks the registers one per clock, from index 0 up to
// DEPTH-1. While it runs, writes are dropped and flagged in the sticky err bit.
//
// Parameters:
//   WIDTH    data width of each register
//   ADDR_W   register select width; DEPTH = 2**ADDR_W
//   BYPASS   1 = forward a same-cycle write to a matching read port
//   ZERO_REG 1 = register 0 reads 0 and ignores writes
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   readReg1Sel  read port 1 select
//   readReg2Sel  read port 2 select
//   writeRegSel  write select
//   writeData    write data
//   writeEn      write enable
//   clearReq     single-cycle request to zero all registers
//   readData1    read port 1 data (combinational)
//   readData2    read port 2 data (combinational)
//   busy         high while the clear sequence runs (registered)
//   err          sticky protocol error: write attempted during clear (registered)
// -----------------------------------------------------------------------------
module rf_param_bypass #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] readReg1Sel,
  input  logic [ADDR_W-1:0] readReg2Sel,
  input  logic [ADDR_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              writeEn,
  input  logic              clearReq,
  output logic [WIDTH-1:0]  readData1,
  output logic [WIDTH-1:0]  readData2,
  output logic              busy,
  output logic              err
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t             state_r;
  state_t             stateNext_s;
  logic [ADDR_W-1:0]  clearCnt_r;
  logic [WIDTH-1:0]   regFile_r [DEPTH];
  logic               busy_r;
  logic               err_r;

  logic               clearLast_s;
  logic               writeOk_s;
  logic               fwdEn_s;

  // True when sel addresses the hardwired zero register.
  function automatic logic isZeroSel(input logic [ADDR_W-1:0] sel);
    return (ZERO_REG != 0) && (sel == ZERO_IDX);
  endfunction

  assign clearLast_s = (state_r == CLEAR) && (clearCnt_r == LAST_IDX);

  // A write lands only in IDLE. Writes aimed at the zero register are
  // dropped silently and are not treated as an error.
  assign writeOk_s = writeEn && (state_r == IDLE) && !isZeroSel(writeRegSel);

  // Forwarding is suppressed during reset so that reads return 0 while rst
  // is held.
  assign fwdEn_s = (BYPASS != 0) && writeEn && (state_r == IDLE) && !rst;

  // Next-state logic of the clear sequencer.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (clearReq) begin
          stateNext_s = CLEAR;
        end else begin
          stateNext_s = IDLE;
        end
      end
      CLEAR: begin
        // A clearReq seen here is ignored: the sequence never restarts.
        if (clearCnt_r == LAST_IDX) begin
          stateNext_s = IDLE;
        end else begin
          stateNext_s = CLEAR;
        end
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Clear index. It is held at 0 in IDLE, so every sequence starts at
  // register 0. Wrapping past DEPTH-1 coincides with the return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clearCnt_r <= ZERO_IDX;
    end else if (state_r == CLEAR) begin
      if (clearLast_s) begin
        clearCnt_r <= ZERO_IDX;
      end else begin
        clearCnt_r <= clearCnt_r + ONE_IDX;
      end
    end else begin
      clearCnt_r <= ZERO_IDX;
    end
  end

  // Register storage.
  // In CLEAR, exactly one register is zeroed per edge.
  // In IDLE, at most one register is written.
  // A write in the same cycle as the clear request still happens; the clear
  // then zeroes that register later in the sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state_r == CLEAR) begin
          if (clearCnt_r == ADDR_W'(i)) begin
            regFile_r[i] <= {WIDTH{1'b0}};
          end else begin
            regFile_r[i] <= regFile_r[i];
          end
        end else if (writeOk_s && (writeRegSel == ADDR_W'(i))) begin
          regFile_r[i] <= writeData;
        end else begin
          regFile_r[i] <= regFile_r[i];
        end
      end
    end
  end

  // Busy flag. It tracks the sequencer state one edge early, so it is high
  // for exactly DEPTH cycles per clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (stateNext_s == CLEAR);
    end
  end

  // Sticky protocol error: a write attempted while clearing. Only rst
  // releases it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((state_r == CLEAR) && writeEn) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Read port 1: zero register, then forwarding, then stored contents.
  always_comb begin
    readData1 = regFile_r[readReg1Sel];
    if (isZeroSel(readReg1Sel)) begin
      readData1 = {WIDTH{1'b0}};
    end else if (fwdEn_s && (writeRegSel == readReg1Sel)) begin
      readData1 = writeData;
    end else begin
      readData1 = regFile_r[readReg1Sel];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    readData2 = regFile_r[readReg2Sel];
    if (isZeroSel(readReg2Sel)) begin
      readData2 = {WIDTH{1'b0}};
    end else if (fwdEn_s && (writeRegSel == readReg2Sel)) begin
      readData2 = writeData;
    end else begin
      readData2 = regFile_r[readReg2Sel];
    end
  end

  assign busy = busy_r;
  assign err  = err_r;

endmodule

// File: tb/tb_rf_param_bypass.sv
// -----------------------------------------------------------------------------
// tb_rf_param_bypass
//
// Drives three configurations of rf_param_bypass from shared inputs:
//   - forwarding on
//   - forwarding off
//   - forwarding on with a hardwired zero register
//
// All three are compared every cycle against a behavioural register-file
// model. Directed steps are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_rf_param_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic        clr;
  logic [2:0]  s1;
  logic [2:0]  s2;
  logic [2:0]  ws;
  logic [15:0] wd;

  logic [15:0] rd1B, rd2B, rd1N, rd2N, rd1Z, rd2Z;
  logic        busyB, errB, busyN, errN, busyZ, errZ;

  // Reference model state.
  logic [15:0] mem [8];
  bit          busyM;
  bit          errM;
  int          clrPos;

  int nAsserts = 0;
  int nFail    = 0;

  always #5 clk = ~clk;

  rf_param_bypass #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dutB (
    .clk(clk), .rst(rst), .readReg1Sel(s1), .readReg2Sel(s2), .writeRegSel(ws),
    .writeData(wd), .writeEn(we), .clearReq(clr), .readData1(rd1B),
    .readData2(rd2B), .busy(busyB), .err(errB));

  rf_param_bypass #(.WIDTH(16), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dutN (
    .clk(clk), .rst(rst), .readReg1Sel(s1), .readReg2Sel(s2), .writeRegSel(ws),
    .writeData(wd), .writeEn(we), .clearReq(clr), .readData1(rd1N),
    .readData2(rd2N), .busy(busyN), .err(errN));

  rf_param_bypass #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dutZ (
    .clk(clk), .rst(rst), .readReg1Sel(s1), .readReg2Sel(s2), .writeRegSel(ws),
    .writeData(wd), .writeEn(we), .clearReq(clr), .readData1(rd1Z),
    .readData2(rd2Z), .busy(busyZ), .err(errZ));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // What a read port should show right now for a given configuration.
  function automatic logic [15:0] expRead(input bit byp, input bit zr, input logic [2:0] sel);
    if (rst) return 16'h0000;
    if (zr && sel == 3'd0) return 16'h0000;
    if (byp && we && !busyM && sel == ws) return wd;
    return mem[sel];
  endfunction

  task automatic checkAll(input string tag);
    chk({tag, ".B.rd1"}, rd1B, expRead(1'b1, 1'b0, s1));
    chk({tag, ".B.rd2"}, rd2B, expRead(1'b1, 1'b0, s2));
    chk({tag, ".N.rd1"}, rd1N, expRead(1'b0, 1'b0, s1));
    chk({tag, ".N.rd2"}, rd2N, expRead(1'b0, 1'b0, s2));
    chk({tag, ".Z.rd1"}, rd1Z, expRead(1'b1, 1'b1, s1));
    chk({tag, ".Z.rd2"}, rd2Z, expRead(1'b1, 1'b1, s2));
    chk({tag, ".B.busy"}, {15'd0, busyB}, {15'd0, busyM});
    chk({tag, ".N.busy"}, {15'd0, busyN}, {15'd0, busyM});
    chk({tag, ".Z.busy"}, {15'd0, busyZ}, {15'd0, busyM});
    chk({tag, ".B.err"}, {15'd0, errB}, {15'd0, errM});
    chk({tag, ".N.err"}, {15'd0, errN}, {15'd0, errM});
    chk({tag, ".Z.err"}, {15'd0, errZ}, {15'd0, errM});
  endtask

  // Apply the rules of one rising edge to the model, using the inputs held
  // at that edge.
  task automatic modelEdge();
    if (busyM) begin
      mem[clrPos] = 16'h0000;
      if (we) errM = 1'b1;
      clrPos++;
      if (clrPos == 8) begin
        busyM  = 1'b0;
        clrPos = 0;
      end
    end else begin
      if (we) mem[ws] = wd;
      if (clr) begin
        busyM  = 1'b1;
        clrPos = 0;
      end
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    busyM  = 1'b0;
    errM   = 1'b0;
    clrPos = 0;
  endtask

  // One clock: check mid-cycle, take the edge, advance the model.
  task automatic cycle(input string tag);
    #1;
    checkAll(tag);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  // Assert rst between edges and check that the outputs drop at once.
  task automatic asyncReset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    chk({tag, ".busyNow"}, {15'd0, busyB}, 16'h0000);
    chk({tag, ".errNow"}, {15'd0, errB}, 16'h0000);
    chk({tag, ".rd1Now"}, rd1B, 16'h0000);
    chk({tag, ".rd2Now"}, rd2N, 16'h0000);
    checkAll(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill(input logic [15:0] val);
    we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ws = 3'(i);
      wd = val;
      cycle("fill");
    end
    we = 1'b0;
  endtask

  initial begin
    int cnt;
    int guard;

    rst = 1'b1; we = 1'b0; clr = 1'b0;
    s1 = 3'd0; s2 = 3'd0; ws = 3'd0; wd = 16'h0000;
    modelReset();
    #3;
    checkAll("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Write every register, then read back in crossed order.
    we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ws = 3'(i);
      wd = 16'(16'h1111 * i);
      cycle("wr");
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s1 = 3'(i);
      s2 = 3'(7 - i);
      #1;
      chk("rdall.N.rd1", rd1N, 16'(16'h1111 * i));
      chk("rdall.N.rd2", rd2N, 16'(16'h1111 * (7 - i)));
      cycle("rdall");
    end

    // Forwarding versus registered visibility.
    we = 1'b1; ws = 3'd3; wd = 16'h00AA;
    cycle("byp.pre");
    wd = 16'hBEEF; s1 = 3'd3; s2 = 3'd2;
    #1;
    chk("byp.B.rd1", rd1B, 16'hBEEF);
    chk("byp.B.rd2", rd2B, 16'h2222);
    chk("byp.N.rd1", rd1N, 16'h00AA);
    cycle("byp");
    we = 1'b0;
    #1;
    chk("byp.N.next", rd1N, 16'hBEEF);
    cycle("byp.next");

    // Hardwired zero register: write is discarded and not forwarded.
    we = 1'b1; ws = 3'd0; wd = 16'h1234; s1 = 3'd0;
    #1;
    chk("zero.before", rd1Z, 16'h0000);
    cycle("zero");
    we = 1'b0;
    #1;
    chk("zero.after", rd1Z, 16'h0000);
    chk("zero.err", {15'd0, errZ}, 16'h0000);
    cycle("zero.after");

    // Bulk clear: busy for exactly 8 cycles, everything reads 0 afterwards.
    fill(16'hFFFF);
    clr = 1'b1;
    cycle("clr.req");
    clr = 1'b0;
    cnt = 0; guard = 0;
    while (busyB && guard < 20) begin
      cnt++; guard++;
      s1 = 3'(cnt - 1);
      s2 = 3'(cnt);
      cycle("clr.run");
    end
    chk("clr.busyLen", 16'(cnt), 16'd8);
    for (int i = 0; i < 4; i++) begin
      s1 = 3'(i);
      s2 = 3'(i + 4);
      #1;
      chk("clr.done.rd1", rd1B, 16'h0000);
      chk("clr.done.rd2", rd2N, 16'h0000);
      cycle("clr.done");
    end

    // Write during clear; clearReq while busy must not extend the sequence.
    fill(16'hFFFF);
    clr = 1'b1;
    cycle("wdc.req");
    clr = 1'b0;
    cycle("wdc.b1");
    clr = 1'b1;
    cycle("wdc.b2");
    clr = 1'b0;
    we = 1'b1; ws = 3'd5; wd = 16'h5555;
    cycle("wdc.b3");
    we = 1'b0;
    cnt = 3; guard = 0;
    while (busyB && guard < 20) begin
      cnt++; guard++;
      cycle("wdc.run");
    end
    chk("wdc.busyLen", 16'(cnt), 16'd8);
    s1 = 3'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wdc.reg5", rd1B, 16'h0000);
      chk("wdc.err", {15'd0, errB}, 16'h0001);
      cycle("wdc.after");
    end

    // Reset in the middle of a clear.
    asyncReset("rst0");
    fill(16'hFFFF);
    clr = 1'b1;
    cycle("mid.req");
    clr = 1'b0;
    cycle("mid.b1");
    cycle("mid.b2");
    cycle("mid.b3");
    s1 = 3'd7; s2 = 3'd6;
    asyncReset("mid.rst");
    we = 1'b1; ws = 3'd6; wd = 16'h6666;
    cycle("mid.wr");
    we = 1'b0; s1 = 3'd6;
    #1;
    chk("mid.wrback", rd1N, 16'h6666);
    cycle("mid.wrback");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      s1  = 3'($urandom_range(0, 7));
      s2  = 3'($urandom_range(0, 7));
      ws  = 3'($urandom_range(0, 7));
      wd  = 16'($urandom);
      cycle("rand");
      if ($urandom_range(0, 99) == 0) asyncReset("rand.rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
